spi_cmd_fifo: RTL
=================

# spi_cmd_fifo

Command buffer between the SPI slave receive side and the PWM register interface. It captures every 32-bit word the SPI slave flags as received, queues it, and replays each word to the register interface as a one-cycle write strobe. Replay is paced by a programmable minimum gap and can be stalled by a hold input. The block also counts dropped words and builds a 32-bit status word that the SPI slave transmit path can return to the host.

## Interface
Parameters:
- `WIDTH`, 32: word width; matches the SPI frame width.
- `DEPTH`, 4: number of FIFO entries; power of two, ≥ 2.
- `GAP`, 2: minimum number of idle cycles between two `o_data_we` pulses; 0 allows back-to-back pulses.

Ports (one clock; reset is asynchronous and active-low):
- `clk`  in  1  system clock; all logic on the rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `i_rx_data`  in  WIDTH  received SPI word; valid in the cycle `i_rx_int`=1.
- `i_rx_int`  in  1  one-cycle push strobe from the SPI slave.
- `i_hold`  in  1  downstream stall; while 1, no pop occurs.
- `i_clr_ovf`  in  1  one-cycle clear for the overflow flag and the drop counter.
- `o_data`  out  WIDTH  word presented to the register interface.
- `o_data_we`  out  1  one-cycle write strobe qualifying `o_data`.
- `o_count`  out  $clog2(DEPTH)+1  current occupancy.
- `o_empty`  out  1  1 when `o_count`==0.
- `o_full`  out  1  1 when `o_count`==DEPTH.
- `o_overflow`  out  1  sticky; set when a word is dropped.
- `o_status`  out  32  status word for the SPI transmit path (registered).

## Operation
- Storage: circular buffer of DEPTH×WIDTH words.
  - Read and write pointers are $clog2(DEPTH) bits wide and wrap modulo DEPTH.
  - A separate occupancy counter drives `o_count`, `o_empty` and `o_full`.
- Push: occurs when `i_rx_int`=1 and either the FIFO is not full or a pop happens in the same cycle.
  - Simultaneous push and pop leaves the count unchanged, including when the FIFO is full.
- Drop: `i_rx_int`=1, FIFO full, and no pop in that cycle.
  - The word is discarded and `o_overflow` is set.
  - `drop_cnt` (8 bits) increments and saturates at 255.
- Pop condition: `!o_empty && !i_hold && gap_cnt==0`.
  - On a pop, `o_data` is loaded with the head word and `o_data_we`=1 for exactly one cycle.
  - `o_data` holds that value until the next pop.
- Gap counter:
  - Loaded with GAP on each pop.
  - Decrements by 1 per cycle down to 0.
  - Keeps decrementing while `i_hold`=1, so a hold does not extend the gap.
- Clear: `i_clr_ovf`=1 clears `o_overflow` and `drop_cnt`.
  - If a drop occurs in the same cycle, the drop wins: `o_overflow`=1 and `drop_cnt`=1.
- Status word:
  - `[31]` = `o_overflow`
  - `[30:24]` = 0
  - `[23:16]` = `drop_cnt`
  - `[15:8]` = 0
  - `[7:0]` = `o_count`, zero-extended
  - Registered, so it reflects state one cycle later.
- No state machine beyond the pointers and counters. The block is always ready to accept a push; there is no back-pressure to the SPI slave.

## Timing
- Reset (`reset_n`=0, asynchronous): pointers, count, `gap_cnt`, `drop_cnt`, `o_overflow`, `o_data_we`, `o_data` and `o_status` all go to 0; `o_empty`=1 and `o_full`=0. FIFO contents are not cleared.
- Reset in the middle of a burst discards all queued words. The first push after `reset_n` rises is treated as if the FIFO were empty.
- Latency: a push sampled at edge E0 into an empty FIFO, with `i_hold`=0 and `gap_cnt`=0, gives `o_data_we`=1 in the cycle after edge E1.
- Pacing: with a pop at edge Ek, the next pop occurs no earlier than edge Ek+GAP+1.
- `o_count`, `o_empty` and `o_full` update on the edge at which the push or pop is sampled.
- A pop on the same edge that `i_hold` rises still happens; `i_hold` is sampled, not combinational to the output.

## Test plan
- Single word, GAP=2: push 0xA5A5_0001 → `o_data_we` pulses for one cycle with `o_data`=0xA5A5_0001 one cycle after the push edge; afterwards `o_count`=0 and `o_empty`=1.
- Burst pacing, GAP=2: 4 back-to-back pushes 0x1..0x4 → 4 pulses in order, exactly 3 cycles apart; `o_count` peaks at 3.
- Overflow, `i_hold`=1: push 6 words → `o_full`=1, `o_overflow`=1, `drop_cnt`=2, `o_status`=0x8002_0004; release hold → words 1-4 are replayed and words 5-6 never appear.
- Clear collision: FIFO full, hold high, `i_clr_ovf` and `i_rx_int` in the same cycle → `o_overflow`=1 and `drop_cnt`=1.
- Full with simultaneous push and pop: FIFO full, hold drops, push in the same cycle as the pop → no drop, `o_count` stays 4, and the new word appears fifth in replay order.
- Asynchronous reset with 3 words queued and hold high: all outputs return to their reset values immediately, with no further `o_data_we`; a fresh push then replays after 1 cycle.

Source files
------------

// File: rtl/spi_cmd_fifo.sv
// Queues SPI-received words and replays each as a one-cycle register write, at least GAP idle cycles apart.
// Push-to-strobe latency is one cycle; no back-pressure to the SPI side, so words arriving while full are dropped and counted.
module spi_cmd_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4,
  parameter int GAP   = 2
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic [WIDTH-1:0]       i_rx_data,
  input  logic                   i_rx_int,
  input  logic                   i_hold,
  input  logic                   i_clr_ovf,
  output logic [WIDTH-1:0]       o_data,
  output logic                   o_data_we,
  output logic [$clog2(DEPTH):0] o_count,
  output logic                   o_empty,
  output logic                   o_full,
  output logic                   o_overflow,
  output logic [31:0]            o_status
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int GW = (GAP > 0) ? $clog2(GAP + 1) : 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [CW-1:0]    count;
  logic [GW-1:0]    gap_cnt;
  logic [7:0]       drop_cnt;
  logic             push;
  logic             pop;
  logic             drop;

  // A pop frees a slot in the same cycle, so a push into a full FIFO is still accepted then.
  assign pop  = !o_empty && !i_hold && (gap_cnt == '0);
  assign push = i_rx_int && (!o_full || pop);
  assign drop = i_rx_int && o_full && !pop;

  assign o_count = count;
  assign o_empty = (count == '0);
  assign o_full  = (count == CW'(DEPTH));

  // Storage is deliberately not reset; the pointers and count define what is valid.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= i_rx_data;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      gap_cnt    <= '0;
      drop_cnt   <= '0;
      o_overflow <= 1'b0;
      o_data_we  <= 1'b0;
      o_data     <= '0;
      o_status   <= '0;
    end else begin
      o_data_we <= pop;

      if (push) wr_ptr <= wr_ptr + AW'(1);

      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
        o_data <= mem[rd_ptr];
      end

      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase

      // The gap keeps running during hold so a stall never lengthens the spacing.
      if (pop)                gap_cnt <= GW'(GAP);
      else if (gap_cnt != '0) gap_cnt <= gap_cnt - GW'(1);

      if (drop) begin
        o_overflow <= 1'b1;
        if (i_clr_ovf)              drop_cnt <= 8'd1;
        else if (drop_cnt != 8'hFF) drop_cnt <= drop_cnt + 8'd1;
      end else if (i_clr_ovf) begin
        o_overflow <= 1'b0;
        drop_cnt   <= 8'd0;
      end

      o_status <= {o_overflow, 7'd0, drop_cnt, 8'd0, 8'(count)};
    end
  end

endmodule
